fixed_to_fp_pipe: RTL and testbench

//  Parametrised, pipelined signed/unsigned fixed-point -> IEEE-754 binary32 converter with

---
 rtl/fixed_to_fp_pkg.sv | 20 ++
 rtl/fixed_to_fp_pipe_lzc.sv | 27 ++
 rtl/fixed_to_fp_pipe.sv | 162 ++++++++++++++++
 tb/tb_fixed_to_fp_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_to_fp_pkg.sv
// Shared types and constants for the fixed-point to binary32 converter.
// Round-to-nearest-even is selected by defining FIXED_TO_FP_RNE_EN.
package fixed_to_fp_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;
  localparam int F32_EXP_W  = 8;

  typedef struct packed {
    logic                  sign;
    logic [F32_EXP_W-1:0]  exp;
    logic [F32_MANT_W-1:0] mant;
  } f32_t;

  // Count must be able to represent w itself (all-zero operand).
  function automatic int lzc_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fixed_to_fp_pipe_lzc.sv
// Combinational leading-zero counter with zero flag; count equals W for an all-zero operand.
module fx_lzc
  import fixed_to_fp_pkg::*;
#(
  parameter  int W  = 20,
  localparam int CW = lzc_cnt_w(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic found;

  always_comb begin
    count = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        count = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
    zero = ~found;
  end

endmodule

// File: rtl/fixed_to_fp_pipe.sv
// Three-stage elastic fixed-point -> IEEE-754 binary32 converter (sign/magnitude, normalise, pack).
// Define FIXED_TO_FP_RNE_EN for round-to-nearest-even; otherwise excess bits are truncated.
module fixed_to_fp_pipe
  import fixed_to_fp_pkg::*;
#(
  parameter int IN_W   = 19,
  parameter int FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
);

  // One extra bit keeps the magnitude of the most-negative input from wrapping.
  localparam int MAG_W   = IN_W + 1;
  localparam int LZC_W   = lzc_cnt_w(MAG_W);
  localparam int EXT_W   = 56;
  localparam int MR_W    = F32_MANT_W + 1;
  localparam int EXP_OFS = MAG_W - 1 - FRAC_W + F32_BIAS;

  generate
    if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
      $error("fixed_to_fp_pipe: IN_W must be in 2..32");
    end
    if (FRAC_W < 0 || FRAC_W > IN_W) begin : g_bad_frac_w
      $error("fixed_to_fp_pipe: FRAC_W must be in 0..IN_W");
    end
  endgenerate

  logic             s1_v_q, s1_v_d;
  logic             s1_sign_q, s1_sign_d;
  logic [MAG_W-1:0] s1_mag_q, s1_mag_d;

  logic             s2_v_q, s2_v_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_zero_q, s2_zero_d;
  logic [LZC_W-1:0] s2_lzc_q, s2_lzc_d;
  logic [IN_W-1:0]  s2_frac_q, s2_frac_d;

  logic             s3_v_q, s3_v_d;
  f32_t             s3_data_q, s3_data_d;

  logic s1_load, s2_load, s3_load;

  // Stall chain: each stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    s3_load  = s2_v_q & (~s3_v_q | out_ready);
    s2_load  = s1_v_q & (~s2_v_q | s3_load);
    in_ready = ~s1_v_q | s2_load;
    s1_load  = in_valid & in_ready;

    s1_v_d = s1_load | (s1_v_q & ~s2_load);
    s2_v_d = s2_load | (s2_v_q & ~s3_load);
    s3_v_d = s3_load | (s3_v_q & ~out_ready);
  end

  logic             in_neg;
  logic [MAG_W-1:0] in_ext;

  always_comb begin
    in_neg    = in_signed & in_data[IN_W-1];
    in_ext    = {in_neg, in_data};
    s1_sign_d = s1_sign_q;
    s1_mag_d  = s1_mag_q;
    if (s1_load) begin
      s1_sign_d = in_neg;
      s1_mag_d  = in_neg ? (~in_ext + MAG_W'(1)) : in_ext;
    end
  end

  logic [LZC_W-1:0] s1_lzc;
  logic             s1_zero;

  fx_lzc #(.W(MAG_W)) u_lzc (
    .data  (s1_mag_q),
    .count (s1_lzc),
    .zero  (s1_zero)
  );

  // The leading 1 lands on the dropped MSB; only the bits below it are kept.
  always_comb begin
    s2_sign_d = s2_sign_q;
    s2_zero_d = s2_zero_q;
    s2_lzc_d  = s2_lzc_q;
    s2_frac_d = s2_frac_q;
    if (s2_load) begin
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero;
      s2_lzc_d  = s1_lzc;
      s2_frac_d = IN_W'(s1_mag_q << s1_lzc);
    end
  end

  logic [EXT_W-1:0]      frac_ext;
  logic [F32_MANT_W-1:0] mant_t;
  logic                  round_up;
  logic [MR_W-1:0]       mant_r;
  f32_t                  res;

`ifdef FIXED_TO_FP_RNE_EN
  logic guard_bit, sticky_bit;
  always_comb begin
    guard_bit  = frac_ext[EXT_W-1-F32_MANT_W];
    sticky_bit = |frac_ext[EXT_W-2-F32_MANT_W:0];
    round_up   = guard_bit & (sticky_bit | mant_t[0]);
  end
`else
  logic unused_round_bits;
  assign unused_round_bits = ^frac_ext[EXT_W-1-F32_MANT_W:0];
  assign round_up          = 1'b0;
`endif

  // A carry out of the rounded mantissa bumps the exponent; the mantissa is then zero.
  always_comb begin
    frac_ext  = {s2_frac_q, {(EXT_W - IN_W){1'b0}}};
    mant_t    = frac_ext[EXT_W-1 -: F32_MANT_W];
    mant_r    = {1'b0, mant_t} + MR_W'(round_up);
    res.sign  = s2_sign_q & ~s2_zero_q;
    res.exp   = F32_EXP_W'(EXP_OFS - int'(s2_lzc_q) + int'(mant_r[F32_MANT_W]));
    res.mant  = mant_r[F32_MANT_W-1:0];
    if (s2_zero_q) begin
      res = '0;
    end
    s3_data_d = s3_load ? res : s3_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_lzc_q  <= '0;
      s2_frac_q <= '0;
      s3_v_q    <= 1'b0;
      s3_data_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_v_q    <= s2_v_d;
      s2_sign_q <= s2_sign_d;
      s2_zero_q <= s2_zero_d;
      s2_lzc_q  <= s2_lzc_d;
      s2_frac_q <= s2_frac_d;
      s3_v_q    <= s3_v_d;
      s3_data_q <= s3_data_d;
    end
  end

  assign out_valid = s3_v_q;
  assign out_data  = s3_data_q;

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
// Scoreboard bench for fixed_to_fp_pipe: a Q3.16 instance and a 32-bit integer instance.
module tb_fixed_to_fp_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [18:0] a_in_data;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic [31:0] b_out_data;

  int errors = 0;
  int checks = 0;
  int n_out_a = 0;
  int n_out_b = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  always #5 clk = ~clk;

  fixed_to_fp_pipe #(.IN_W(19), .FRAC_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_signed(a_in_signed),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  fixed_to_fp_pipe #(.IN_W(32), .FRAC_W(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_signed(b_in_signed),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  // Reference for the Q3.16 instance via double precision; 19 bits always fit a binary32 exactly.
  function automatic logic [31:0] ref19(input logic [18:0] d, input logic s);
    int          v;
    real         r;
    logic [63:0] bits;
    logic [7:0]  e;
    if (s) v = int'($signed(d));
    else   v = int'(d);
    if (v == 0) return 32'h0;
    r    = real'(v) / 65536.0;
    bits = $realtobits(r);
    e    = 8'(int'(bits[62:52]) - 1023 + 127);
    return {bits[63], e, bits[51:29]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      n_out_a++;
      checks++;
      assert (exp_a.size() != 0) else begin
        errors++;
        $error("FAIL a_unexpected got=%h exp=none", a_out_data);
      end
      if (exp_a.size() != 0) chk("a_data", a_out_data, exp_a.pop_front());
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      n_out_b++;
      checks++;
      assert (exp_b.size() != 0) else begin
        errors++;
        $error("FAIL b_unexpected got=%h exp=none", b_out_data);
      end
      if (exp_b.size() != 0) chk("b_data", b_out_data, exp_b.pop_front());
    end
  end

  task automatic send_a(input logic [18:0] d, input logic s, input logic [31:0] e);
    logic acc;
    int   n;
    n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_signed = s;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      if (acc) exp_a.push_back(e);
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("a_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic s, input logic [31:0] e);
    logic acc;
    int   n;
    n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_signed = s;
    do begin
      @(negedge clk);
      acc = b_in_ready;
      if (acc) exp_b.push_back(e);
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("b_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_a", 32'(exp_a.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] bp_w[5];
    logic        acc;
    int          idx, base;
    logic [18:0] rd;
    logic        rs;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_signed = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_signed = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data",  a_out_data,       32'h0);
    chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed Q3.16 values, signed and unsigned interpretation of the same word
    send_a(19'h10000, 1'b1, 32'h3F80_0000);
    send_a(19'h70000, 1'b1, 32'hBF80_0000);
    send_a(19'h40000, 1'b1, 32'hC080_0000);
    send_a(19'h00001, 1'b1, 32'h3780_0000);
    send_a(19'h00000, 1'b1, 32'h0000_0000);
    send_a(19'h40000, 1'b0, 32'h4080_0000);
    send_a(19'h7FFFF, 1'b0, ref19(19'h7FFFF, 1'b0));
    drain();

    // Latency: accepted word appears on the third cycle after acceptance
    send_a(19'h18000, 1'b1, 32'h3FC0_0000);
    a_in_valid = 1'b0;
    @(negedge clk); chk("lat_c1", 32'(a_out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("lat_c2", 32'(a_out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("lat_c3", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Pseudo-random words back to back
    for (int i = 0; i < 10; i++) begin
      rd = 19'($urandom_range(0, 19'h7FFFF));
      rs = 1'($urandom_range(0, 1));
      send_a(rd, rs, ref19(rd, rs));
    end
    drain();

    // Backpressure: sink stalled six cycles while five words are offered
    bp_w[0] = 19'h08000; bp_w[1] = 19'h7C000; bp_w[2] = 19'h00100;
    bp_w[3] = 19'h3FFFF; bp_w[4] = 19'h4A5A5;
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      a_in_valid = (idx < 5); a_in_data = bp_w[(idx < 5) ? idx : 4]; a_in_signed = 1'b1;
      @(negedge clk);
      if (c >= 3) begin
        chk("bp_out_valid", 32'(a_out_valid), 32'd1);
        chk("bp_in_ready",  32'(a_in_ready),  32'd0);
        chk("bp_hold",      a_out_data,       exp_a[0]);
      end
      acc = a_in_valid & a_in_ready;
      if (acc) begin
        exp_a.push_back(ref19(a_in_data, 1'b1));
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(idx), 32'd3);
    base = n_out_a;
    a_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = (idx < 5); a_in_data = bp_w[(idx < 5) ? idx : 4]; a_in_signed = 1'b1;
      @(negedge clk);
      acc = a_in_valid & a_in_ready;
      if (acc) begin
        exp_a.push_back(ref19(a_in_data, 1'b1));
        idx++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    chk("bp_total_in",  32'(idx),            32'd5);
    chk("bp_rate",      32'(n_out_a - base), 32'd5);
    chk("bp_queue",     32'(exp_a.size()),   32'd0);

    // 32-bit integer instance: rounding and exponent carry
`ifdef FIXED_TO_FP_RNE_EN
    send_b(32'h0100_0003, 1'b0, 32'h4B80_0002);
    send_b(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000);
    send_b(32'h0100_0007, 1'b0, 32'h4B80_0004);
`else
    send_b(32'h0100_0003, 1'b0, 32'h4B80_0001);
    send_b(32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF);
    send_b(32'h0100_0007, 1'b0, 32'h4B80_0003);
`endif
    send_b(32'h0100_0001, 1'b0, 32'h4B80_0000);
    send_b(32'h0000_0001, 1'b0, 32'h3F80_0000);
    send_b(32'h0000_0000, 1'b1, 32'h0000_0000);
    send_b(32'h8000_0000, 1'b1, 32'hCF00_0000);
    send_b(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000);
    send_b(32'h0000_00FF, 1'b0, 32'h437F_0000);
    drain();

    // Reset with two words in flight: nothing from before reset may emerge
    a_out_ready = 1'b0;
    send_a(19'h10000, 1'b1, 32'h3F80_0000);
    send_a(19'h20000, 1'b1, 32'h4000_0000);
    a_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_pre_valid", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(a_out_valid), 32'd0);
    chk("rst_mid_data",  a_out_data,       32'h0);
    exp_a.delete();
    base = n_out_a;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("rst_no_stale", 32'(n_out_a - base), 32'd0);

    send_a(19'h7F000, 1'b1, 32'hBD80_0000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
